// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared types and constants for the weight SRAM fetch path.
package weight_pkg;

  localparam int unsigned WGT_WORDS = 16384;
  localparam int unsigned WGT_IDX_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } wfc_state_t;

  // One output beat: lane mask plus {odd word, even word}.
  typedef struct packed {
    logic [1:0]  mask;
    logic [63:0] data;
  } wgt_beat_t;

  // Word index arithmetic wraps naturally at WGT_WORDS.
  function automatic logic [WGT_IDX_W-1:0] wgt_idx_add(
    input logic [WGT_IDX_W-1:0] a,
    input logic [WGT_IDX_W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Command, output-beat and loader-write handshakes of the weight fetch controller.
interface weight_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 15
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;

  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic [1:0]        out_mask;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;

  // Layer controller / loader / PE side.
  modport master (
    output cmd_valid, cmd_base, cmd_len, out_ready, wr_valid, wr_addr, wr_data, wr_be,
    input  cmd_ready, out_valid, out_data, out_mask, wr_ready
  );

  // Fetch controller side.
  modport slave (
    input  cmd_valid, cmd_base, cmd_len, out_ready, wr_valid, wr_addr, wr_data, wr_be,
    output cmd_ready, out_valid, out_data, out_mask, wr_ready
  );
endinterface

// File: rtl/weight_fetch_ctrl_beat_fifo.sv
// First-word-fall-through beat FIFO with occupancy count.
module weight_beat_fifo
  import weight_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wgt_beat_t                push_beat_i,
  input  logic                     pop_i,
  output wgt_beat_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wgt_beat_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_beat_i;
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM fetch sequencer and port-0 write arbiter.
module weight_fetch_ctrl
  import weight_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LEN_W      = 15,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  weight_fetch_ctrl_if.slave bus,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [3:0]        sram_wea0,
  output logic [31:0]       sram_wdata0,
  input  logic [31:0]       sram_rdata0,
  output logic [ADDR_W-1:0] sram_addr1,
  output logic [3:0]        sram_wea1,
  output logic [31:0]       sram_wdata1,
  input  logic [31:0]       sram_rdata1
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  wfc_state_t           state_q, state_d;
  logic [WGT_IDX_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           infl_mask_q, infl_mask_d;
  logic                 len0_done_q, len0_done_d;

  wgt_beat_t            fifo_head, push_beat;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty, fifo_full;
  logic                 pop, last_beat, issue;
  logic [SUM_W-1:0]     credit_used;

  assign push_beat.mask = infl_mask_q;
  assign push_beat.data = {sram_rdata1, sram_rdata0};

  weight_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_beat_i (push_beat),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head.data;
  assign bus.out_mask  = fifo_head.mask;
  assign pop           = !fifo_empty && bus.out_ready;
  assign busy          = (state_q != IDLE);
  assign sram_wea1     = '0;
  assign sram_wdata1   = '0;

  // The beat leaving this cycle frees its slot before the new read lands, so it
  // is credited back; this keeps a 2-deep FIFO streaming without bubbles.
  assign credit_used = SUM_W'(fifo_count) + SUM_W'(inflight_q) - SUM_W'(pop);
  assign issue       = (state_q == FETCH) && (credit_used < SUM_W'(FIFO_DEPTH));
  assign last_beat   = (state_q == DRAIN) && !inflight_q && (fifo_count == CNT_W'(1)) && pop;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_mask_q <= '0;
      len0_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      infl_mask_q <= infl_mask_d;
      len0_done_q <= len0_done_d;
    end
  end

  // Next-state, handshakes and SRAM port drive.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    inflight_d    = 1'b0;
    infl_mask_d   = infl_mask_q;
    len0_done_d   = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    sram_addr0    = '0;
    sram_addr1    = '0;
    sram_wea0     = '0;
    sram_wdata0   = '0;
    done          = len0_done_q;

    case (state_q)
      IDLE: begin
        bus.wr_ready  = 1'b1;
        bus.cmd_ready = !bus.wr_valid;
        if (bus.wr_valid) begin
          sram_addr0  = ADDR_W'(bus.wr_addr[WGT_IDX_W-1:0]);
          sram_addr1  = ADDR_W'(bus.wr_addr[WGT_IDX_W-1:0]);
          sram_wea0   = bus.wr_be;
          sram_wdata0 = bus.wr_data;
        end else if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            len0_done_d = 1'b1;
          end else begin
            ptr_d   = bus.cmd_base[WGT_IDX_W-1:0];
            rem_d   = bus.cmd_len;
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        if (issue) begin
          inflight_d = 1'b1;
          sram_addr0 = ADDR_W'(ptr_q);
          if (rem_q == LEN_W'(1)) begin
            sram_addr1  = ADDR_W'(ptr_q);
            infl_mask_d = 2'b01;
            rem_d       = '0;
          end else begin
            sram_addr1  = ADDR_W'(wgt_idx_add(ptr_q, WGT_IDX_W'(1)));
            infl_mask_d = 2'b11;
            rem_d       = rem_q - LEN_W'(2);
          end
          ptr_d = wgt_idx_add(ptr_q, WGT_IDX_W'(2));
          if (rem_q <= LEN_W'(2)) state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (last_beat) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with an SRAM model and beat scoreboard.
module tb_weight_fetch_ctrl;
  import weight_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        done, busy;
  logic [15:0] sram_addr0, sram_addr1;
  logic [3:0]  sram_wea0, sram_wea1;
  logic [31:0] sram_wdata0, sram_wdata1, sram_rdata0, sram_rdata1;

  weight_fetch_ctrl_if #(.ADDR_W(16), .LEN_W(15)) wif ();

  weight_fetch_ctrl #(.ADDR_W(16), .LEN_W(15), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (wif),
    .done        (done),
    .busy        (busy),
    .sram_addr0  (sram_addr0),
    .sram_wea0   (sram_wea0),
    .sram_wdata0 (sram_wdata0),
    .sram_rdata0 (sram_rdata0),
    .sram_addr1  (sram_addr1),
    .sram_wea1   (sram_wea1),
    .sram_wdata1 (sram_wdata1),
    .sram_rdata1 (sram_rdata1)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [16384];
  logic [31:0] refm [16384];
  wgt_beat_t   sb [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  bit          tog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port synchronous SRAM: 1-cycle read, read-before-write, port 0 byte writes.
  always @(posedge clk) begin
    sram_rdata0 <= mem[sram_addr0[13:0]];
    sram_rdata1 <= mem[sram_addr1[13:0]];
    for (int b = 0; b < 4; b++)
      if (sram_wea0[b]) mem[sram_addr0[13:0]][8*b +: 8] = sram_wdata0[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // out_ready: held high, or cycling 1,0,0,1 during the backpressure test.
  initial begin
    logic [3:0] pat;
    int unsigned ph;
    pat = 4'b1001;
    ph = 0;
    wif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog) begin
        wif.out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        wif.out_ready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pop on each accepted beat, done tracking, FIFO bound.
  always @(negedge clk) begin
    wgt_beat_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst) chk("fifo_count_le_4", 64'(dut.fifo_count <= 4), 64'd1);
    if (!rst && wif.out_valid && wif.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("beat_mask", 64'(wif.out_mask), 64'(e.mask));
        if (e.mask == 2'b01) chk("beat_tail_lo", 64'(wif.out_data[31:0]), 64'(e.data[31:0]));
        else                 chk("beat_data", wif.out_data, e.data);
      end
    end
  end

  task automatic push_expected(input logic [15:0] base, input int unsigned len);
    wgt_beat_t b;
    int unsigned e, o;
    for (int unsigned i = 0; i < (len + 1) / 2; i++) begin
      e = (int'(base[13:0]) + 2 * i) % 16384;
      o = (e + 1) % 16384;
      if (2 * i + 1 == len) begin
        b.mask = 2'b01;
        b.data = {32'h0, refm[e]};
      end else begin
        b.mask = 2'b11;
        b.data = {refm[o], refm[e]};
      end
      sb.push_back(b);
    end
  endtask

  // Called just after a posedge; returns just after the accepting edge (cycle T+1).
  task automatic send_cmd(input string tag, input logic [15:0] base, input int unsigned len,
                          output int t);
    push_expected(base, len);
    wif.cmd_valid = 1'b1;
    wif.cmd_base  = base;
    wif.cmd_len   = 15'(len);
    t = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wif.cmd_ready) begin
        t = cyc;
        break;
      end
    end
    chk({tag, "_cmd_accept"}, 64'(t >= 0), 64'd1);
    @(posedge clk);
    #1;
    wif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_complete"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t_wr, d0;
    rst = 1'b1;
    wif.cmd_valid = 1'b0; wif.cmd_base = '0; wif.cmd_len = '0;
    wif.wr_valid  = 1'b0; wif.wr_addr  = '0; wif.wr_data = '0; wif.wr_be = '0;
    for (int i = 0; i < 16384; i++) begin
      mem[i]  = 32'(i);
      refm[i] = 32'(i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(wif.out_valid), 64'd0);
    chk("rst_cmd_ready", 64'(wif.cmd_ready), 64'd1);
    chk("rst_wr_ready", 64'(wif.wr_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sram_addr0", 64'(sram_addr0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: base 0, len 8, latency and done timing
    d0 = done_cnt;
    send_cmd("t1", 16'd0, 8, t);
    @(negedge clk); chk("t1_valid_T+1", 64'(wif.out_valid), 64'd0);
    @(negedge clk); chk("t1_valid_T+2", 64'(wif.out_valid), 64'd0);
    @(negedge clk); chk("t1_valid_T+3", 64'(wif.out_valid), 64'd1);
    wait_idle("t1", 50);
    chk("t1_done_cycle", 64'(done_cyc), 64'(t + 6));
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);

    // Test 2: wrap-around with odd tail
    d0 = done_cnt;
    send_cmd("t2", 16'd16382, 5, t);
    wait_idle("t2", 50);
    chk("t2_done_count", 64'(done_cnt - d0), 64'd1);

    // Test 3: len 16 under 1,0,0,1 backpressure
    d0 = done_cnt;
    tog = 1'b1;
    send_cmd("t3", 16'd0, 16, t);
    wait_idle("t3", 200);
    tog = 1'b0;
    @(posedge clk); #1;
    chk("t3_done_count", 64'(done_cnt - d0), 64'd1);

    // Test 4: write and command together; write wins, command next cycle
    mem[5]  = 32'h11223344;
    refm[5] = 32'h1122CCDD;
    d0 = done_cnt;
    wif.wr_valid = 1'b1; wif.wr_addr = 16'd5; wif.wr_be = 4'b0011; wif.wr_data = 32'hAABBCCDD;
    wif.cmd_valid = 1'b1; wif.cmd_base = 16'd5; wif.cmd_len = 15'd1;
    @(negedge clk);
    t_wr = cyc;
    chk("t4_wr_ready", 64'(wif.wr_ready), 64'd1);
    chk("t4_cmd_blocked", 64'(wif.cmd_ready), 64'd0);
    chk("t4_wea0", 64'(sram_wea0), 64'h3);
    chk("t4_addr1_match", 64'(sram_addr1), 64'd5);
    @(posedge clk); #1;
    wif.wr_valid = 1'b0;
    chk("t4_ram5", 64'(mem[5]), 64'h1122CCDD);
    send_cmd("t4", 16'd5, 1, t);
    chk("t4_cmd_cycle", 64'(t), 64'(t_wr + 1));
    wait_idle("t4", 50);
    chk("t4_done_count", 64'(done_cnt - d0), 64'd1);

    // Test 5: reset during a len 32 fetch, then base 10 len 2
    send_cmd("t5a", 16'd0, 32, t);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_out_valid", 64'(wif.out_valid), 64'd0);
    chk("t5_rst_cmd_ready", 64'(wif.cmd_ready), 64'd1);
    chk("t5_rst_wr_ready", 64'(wif.wr_ready), 64'd1);
    chk("t5_rst_sram_addr", 64'({sram_addr0, sram_addr1}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt;
    send_cmd("t5b", 16'd10, 2, t);
    wait_idle("t5", 50);
    chk("t5_done_count", 64'(done_cnt - d0), 64'd1);

    // Test 6: len 0 completes without any SRAM access
    d0 = done_cnt;
    send_cmd("t6", 16'h0123, 0, t);
    @(negedge clk);
    chk("t6_done_T+1", 64'(done), 64'd1);
    chk("t6_busy_T+1", 64'(busy), 64'd0);
    chk("t6_sram_T+1", 64'({sram_addr0, sram_addr1, sram_wea0}), 64'd0);
    @(negedge clk);
    chk("t6_done_T+2", 64'(done), 64'd0);
    chk("t6_busy_T+2", 64'(busy), 64'd0);
    chk("t6_sram_T+2", 64'({sram_addr0, sram_addr1, sram_wea0}), 64'd0);
    chk("t6_done_count", 64'(done_cnt - d0), 64'd1);

    repeat (3) @(posedge clk);
    chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Sequencer and port arbiter for the dual-port 16384x32b weight SRAM. It accepts fetch commands (base word address, length) from the layer controller and streams weights out as 64-bit beats, reading even and odd words on ports 0 and 1 in parallel. A credit-limited output FIFO absorbs the SRAM's 1-cycle read latency and PE-side backpressure. When no fetch is active, it also arbitrates loader writes into port 0.

## Interface
- ADDR_W, 16, SRAM address port width; only bits [13:0] are significant.
- LEN_W, 15, command length width in words (1..16384; 0 allowed).
- FIFO_DEPTH, 4, output beat FIFO entries (power of 2, ≥2).
- clk  in  1  clock; one clock domain. All SRAM ports and logic use this edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  fetch command handshake.
- cmd_base  in  ADDR_W  first word address.
- cmd_len  in  LEN_W  word count.
- out_valid / out_ready  out / in  1  beat handshake.
- out_data  out  64  {odd word, even word}; the low 32 bits are the first word.
- out_mask  out  2  lane valid; 2'b01 only on an odd-length tail beat.
- done  out  1  one-cycle pulse when the last beat is accepted.
- busy  out  1  state != IDLE.
- wr_valid / wr_ready  in / out  1  loader write handshake.
- wr_addr, wr_data, wr_be  in  ADDR_W, 32, 4  loader write address, data, byte enables.
- sram_addr0, sram_wea0, sram_wdata0  out  ADDR_W, 4, 32  SRAM port 0 drive.
- sram_rdata0  in  32  SRAM port 0 read data.
- sram_addr1, sram_wea1, sram_wdata1  out  ADDR_W, 4, 32  SRAM port 1 drive; sram_wea1 is tied 0.
- sram_rdata1  in  32  SRAM port 1 read data.

## Operation
- FSM states are IDLE, FETCH and DRAIN.
- IDLE:
  - wr_ready = 1. A write has priority over a command, so cmd_ready = !wr_valid.
  - On a write, drive sram_addr0 = sram_addr1 = wr_addr and sram_wea0 = wr_be. Port 1 is given the same address on purpose: the SRAM suppresses a port-1 write-back when the addresses match.
  - When nothing is written, sram_wea0 = 0.
- Command accept:
  - cmd_len = 0: no SRAM access. done pulses the next cycle and the FSM stays in IDLE.
  - Otherwise, latch ptr = cmd_base[13:0] and rem = cmd_len, then go to FETCH.
- FETCH:
  - Issue a read when fifo_count + inflight < FIFO_DEPTH. inflight is 1 if a read was issued in the previous cycle.
  - A read drives sram_addr0 = ptr and sram_addr1 = (ptr+1) mod 16384. Then ptr += 2 (mod 16384) and rem -= min(rem, 2).
  - If rem = 1, issue port 0 only: sram_addr1 = ptr, and the tagged mask is 2'b01.
  - When rem reaches 0, go to DRAIN.
  - wr_ready = 0 in FETCH and DRAIN.
- Read data return:
  - Data from a read issued in cycle N is captured into the FIFO at the end of cycle N+1, together with its mask.
- DRAIN:
  - Wait for inflight = 0 and the FIFO to empty.
  - done pulses on the handshake of the final beat, and the FSM returns to IDLE on the same edge.
- Address arithmetic is 14-bit and wraps 16383 → 0. Bits [15:14] of sram_addr* are always 0.
- Reset at any time:
  - FSM goes to IDLE; FIFO and inflight are cleared.
  - Any read data in flight is discarded.
  - Outputs go to: out_valid = 0, done = 0, busy = 0, cmd_ready = 1, wr_ready = 1, all sram_* = 0.

## Timing
- Command accepted in cycle T:
  - first read is issued in T+1;
  - data is captured at the end of T+2;
  - out_valid = 1 in T+3.
- With out_ready held at 1, throughput is 1 beat (2 words) per cycle sustained. The credit check must not create bubbles at FIFO_DEPTH ≥ 2.
- A length-L command with out_ready = 1 has its last beat in T+2+ceil(L/2); done is asserted in that same cycle.
- A loader write is committed at the edge where wr_valid & wr_ready. A command presented in the same cycle is accepted one cycle later.
- The FIFO never overflows: the credit check counts the read in flight.

## Structure
- Shared package weight_pkg holds:
  - WGT_WORDS = 16384 and WGT_IDX_W = 14;
  - the state enum wfc_state_t {IDLE, FETCH, DRAIN};
  - the beat struct {mask[1:0], data[63:0]}.
- One sub-module, weight_beat_fifo: a synchronous FIFO with async-high reset, a count output, and first-word-fall-through.

## Test plan
- Preload words 0..15 with value = address. Send a command with base 0, len 8 and out_ready = 1. Expect 4 beats {1,0}, {3,2}, {5,4}, {7,6}, the first at T+3, with done on the 4th beat.
- Send a command with base 16382, len 5. Expect beats {16383,16382}, {1,0} and a third beat with mask 01 and data[31:0] = 2. Confirms wrap-around.
- Send len 16 while out_ready toggles 1,0,0,1 repeatedly. Expect no lost or duplicated beats, fifo_count ≤ 4 at all times, and done exactly once.
- Assert wr_valid and cmd_valid together in IDLE, with the write at addr 5, be 4'b0011, data 0xAABBCCDD over an old value of 0x11223344. Expect RAM[5] = 0x1122CCDD, the command accepted the next cycle, and the read returning 0x1122CCDD.
- Pulse rst in the middle of a len 32 fetch, then issue a len 2 command at base 10. Expect busy = 0 and out_valid = 0 right after reset, followed by exactly one beat {11,10}.
- Send a command with len 0. Expect a done pulse at T+1, no sram_* activity, and busy = 0 throughout.
